mem_rw_helper_mp: RTL and testbench

- Multi-port, parametrised successor to the single-port simulation memory helper: one masked write port plus NR_RD independent read channels over one word-addressed backing array.
- Adds valid/ready handshakes, a configurable read latency and per-channel in-order response queues with backpressure.
- Sits between the SoC memory adaptor and the simulation RAM.
- Synthesisable array model; contents are not affected by reset.

---
 rtl/mem_rw_pkg.sv | 24 ++
 rtl/mem_rw_rdq.sv | 57 +++++
 rtl/mem_rw_helper_mp.sv | 158 +++++++++++++++
 tb/tb_mem_rw_helper_mp.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_rw_pkg.sv
// Shared types and helpers for the multi-port simulation memory helper.
// Holds the word-index type, the masked-merge function and credit-counter sizing.
package mem_rw_pkg;

  typedef logic [63:0] index_t;

  // Widest word the merge helper handles; callers cast in and out at their own width.
  localparam int MERGE_W = 1024;
  typedef logic [MERGE_W-1:0] merge_word_t;

  localparam int RDQ_DEPTH_DEF = 4;
  localparam int CNT_W = $clog2(RDQ_DEPTH_DEF + 1);

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic merge_word_t masked_merge(input merge_word_t data,
                                               input merge_word_t mask,
                                               input merge_word_t old);
    return (data & mask) | (old & ~mask);
  endfunction

endpackage

// File: rtl/mem_rw_rdq.sv
// Per-channel response FIFO; the output shows the head while non-empty and
// otherwise holds the last word popped.
module mem_rw_rdq
  import mem_rw_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QW = cnt_width(DEPTH);

  logic [W-1:0]  slot [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [QW-1:0] count;
  logic [W-1:0]  last_q;
  logic          pop_ok;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign valid  = (count != '0);
  assign pop_ok = pop & valid;
  assign data   = valid ? slot[rd_ptr] : last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop_ok) begin
        rd_ptr <= bump(rd_ptr);
        last_q <= slot[rd_ptr];
      end
      if (push && !pop_ok)      count <= count + QW'(1);
      else if (!push && pop_ok) count <= count - QW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) slot[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_rw_helper_mp.sv
// Multi-port simulation memory: one masked write port, NR_RD credit-flowed read channels.
// Optional MEM_RW_OOB_CHECK_EN: out-of-range indices are rejected and flagged on oob_err.
module mem_rw_helper_mp
  import mem_rw_pkg::*;
#(
  parameter int NR_RD      = 2,
  parameter int DATA_W     = 64,
  parameter int DEPTH_LOG2 = 20,
  parameter int RD_LAT     = 2,
  parameter int RDQ_DEPTH  = RDQ_DEPTH_DEF
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [NR_RD-1:0]        r_req_valid,
  output logic [NR_RD-1:0]        r_req_ready,
  input  logic [NR_RD*64-1:0]     r_req_index,
  output logic [NR_RD-1:0]        r_resp_valid,
  input  logic [NR_RD-1:0]        r_resp_ready,
  output logic [NR_RD*DATA_W-1:0] r_resp_data,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [63:0]             w_index,
  input  logic [DATA_W-1:0]       w_data,
  input  logic [DATA_W-1:0]       w_mask,
  output logic                    oob_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CW    = (RDQ_DEPTH == RDQ_DEPTH_DEF) ? CNT_W : cnt_width(RDQ_DEPTH);

  logic [DATA_W-1:0]     mem [WORDS];
  logic                  up_q;
  logic                  w_fire;
  logic                  w_oob;
  logic                  w_en;
  logic [DEPTH_LOG2-1:0] w_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) up_q <= 1'b0;
    else          up_q <= 1'b1;
  end

  assign w_ready = up_q;
  assign w_fire  = w_valid & w_ready;
  assign w_idx   = w_index[DEPTH_LOG2-1:0];

`ifdef MEM_RW_OOB_CHECK_EN
  logic             oob_q;
  logic [NR_RD-1:0] rd_oob_hit;

  assign w_oob = |w_index[63:DEPTH_LOG2];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                           oob_q <= 1'b0;
    else if ((w_fire && w_oob) || |rd_oob_hit) oob_q <= 1'b1;
  end

  assign oob_err = oob_q;
`else
  logic [63-DEPTH_LOG2:0] unused_w_hi;

  assign unused_w_hi = w_index[63:DEPTH_LOG2];
  assign w_oob       = 1'b0;
  assign oob_err     = 1'b0;
`endif

  assign w_en = w_fire & ~w_oob;

  // Array contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (w_en)
      mem[w_idx] <= DATA_W'(masked_merge(MERGE_W'(w_data), MERGE_W'(w_mask), MERGE_W'(mem[w_idx])));
  end

  for (genvar c = 0; c < NR_RD; c++) begin : g_ch
    index_t                idx_full;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  oob;
    logic                  acc;
    logic                  pop;
    logic                  enq_v;
    logic [DATA_W-1:0]     enq_d;
    logic [DATA_W-1:0]     rd_word;
    logic [DATA_W-1:0]     rd_data;
    logic [CW-1:0]         cnt_q;

    assign idx_full = r_req_index[c*64 +: 64];
    assign idx      = idx_full[DEPTH_LOG2-1:0];

`ifdef MEM_RW_OOB_CHECK_EN
    assign oob           = |idx_full[63:DEPTH_LOG2];
    assign rd_oob_hit[c] = acc & oob;
`else
    logic [63-DEPTH_LOG2:0] unused_idx_hi;

    assign unused_idx_hi = idx_full[63:DEPTH_LOG2];
    assign oob           = 1'b0;
`endif

    // Credits come from registered state only, so resp_ready never reaches req_ready.
    assign r_req_ready[c] = up_q && (cnt_q < CW'(RDQ_DEPTH));
    assign acc            = r_req_valid[c] & r_req_ready[c];
    assign pop            = r_resp_valid[c] & r_resp_ready[c];

    // Write-first: a same-cycle write to this word is folded into the read.
    always_comb begin
      rd_word = mem[idx];
      if (w_en && (w_idx == idx))
        rd_word = DATA_W'(masked_merge(MERGE_W'(w_data), MERGE_W'(w_mask), MERGE_W'(rd_word)));
      rd_data = oob ? '0 : rd_word;
    end

    if (RD_LAT == 1) begin : g_nopipe
      assign enq_v = acc;
      assign enq_d = rd_data;
    end else begin : g_pipe
      logic              pv [RD_LAT-1];
      logic [DATA_W-1:0] pd [RD_LAT-1];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          for (int k = 0; k < RD_LAT-1; k++) pv[k] <= 1'b0;
        end else begin
          pv[0] <= acc;
          for (int k = 1; k < RD_LAT-1; k++) pv[k] <= pv[k-1];
        end
      end

      always_ff @(posedge clock) begin
        pd[0] <= rd_data;
        for (int k = 1; k < RD_LAT-1; k++) pd[k] <= pd[k-1];
      end

      assign enq_v = pv[RD_LAT-2];
      assign enq_d = pd[RD_LAT-2];
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          cnt_q <= '0;
      else if (acc && !pop)  cnt_q <= cnt_q + CW'(1);
      else if (!acc && pop)  cnt_q <= cnt_q - CW'(1);
    end

    mem_rw_rdq #(
      .W     (DATA_W),
      .DEPTH (RDQ_DEPTH)
    ) u_rdq (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (enq_v),
      .push_data (enq_d),
      .pop       (pop),
      .valid     (r_resp_valid[c]),
      .data      (r_resp_data[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_mem_rw_helper_mp.sv
// Self-checking bench for mem_rw_helper_mp: reference memory model plus per-channel
// expected-response queues filled on request acceptance and drained on response handshakes.
module tb_mem_rw_helper_mp;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [1:0]   r_req_valid, r_req_ready, r_resp_valid, r_resp_ready;
  logic [127:0] r_req_index, r_resp_data;
  logic         w_valid, w_ready, oob_err;
  logic [63:0]  w_index, w_data, w_mask;

  int checks = 0;
  int errors = 0;

  logic [63:0] ref_mem [int unsigned];
  logic        ref_oob = 1'b0;
  logic [63:0] exp0 [$];
  logic [63:0] exp1 [$];
  logic        hold_v [2];
  logic [63:0] hold_d [2];
  logic [63:0] mon_idx, mon_old, mon_exp, mon_dat;
  int unsigned mon_key;
  int          acc_n;
  int          nxt [2];
  logic [1:0]  acc_now;

`ifdef MEM_RW_OOB_CHECK_EN
  localparam logic [63:0] EXP_IDX3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] EXP_OOB  = 64'd1;
`else
  localparam logic [63:0] EXP_IDX3 = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] EXP_OOB  = 64'd0;
`endif

  always #5 clock = ~clock;

  mem_rw_helper_mp dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .r_req_valid  (r_req_valid),
    .r_req_ready  (r_req_ready),
    .r_req_index  (r_req_index),
    .r_resp_valid (r_resp_valid),
    .r_resp_ready (r_resp_ready),
    .r_resp_data  (r_resp_data),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_index      (w_index),
    .w_data       (w_data),
    .w_mask       (w_mask),
    .oob_err      (oob_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic is_oob(input logic [63:0] idx);
`ifdef MEM_RW_OOB_CHECK_EN
    return |idx[63:20];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [63:0] model_rd(input logic [63:0] idx);
    int unsigned k;
    if (is_oob(idx)) return 64'd0;
    k = 32'(idx[19:0]);
    return ref_mem.exists(k) ? ref_mem[k] : 64'd0;
  endfunction

  // Model update and scoreboard, evaluated mid-cycle ahead of the next active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      hold_v[0] = 1'b0;
      hold_v[1] = 1'b0;
    end else begin
      if (w_valid && w_ready) begin
        if (is_oob(w_index)) ref_oob = 1'b1;
        else begin
          mon_key = 32'(w_index[19:0]);
          mon_old = ref_mem.exists(mon_key) ? ref_mem[mon_key] : 64'd0;
          ref_mem[mon_key] = (w_data & w_mask) | (mon_old & ~w_mask);
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (r_req_valid[c] && r_req_ready[c]) begin
          mon_idx = r_req_index[c*64 +: 64];
          if (is_oob(mon_idx)) ref_oob = 1'b1;
          if (c == 0) exp0.push_back(model_rd(mon_idx));
          else        exp1.push_back(model_rd(mon_idx));
        end
        mon_dat = r_resp_data[c*64 +: 64];
        if (r_resp_valid[c]) begin
          if (hold_v[c]) chk("resp_stable_data", mon_dat, hold_d[c]);
          if (r_resp_ready[c]) begin
            if ((c == 0 && exp0.size() == 0) || (c == 1 && exp1.size() == 0)) begin
              chk("resp_unexpected", 64'(r_resp_valid[c]), 64'd0);
            end else begin
              mon_exp = (c == 0) ? exp0.pop_front() : exp1.pop_front();
              chk(c == 0 ? "resp_data_ch0" : "resp_data_ch1", mon_dat, mon_exp);
            end
          end
          hold_v[c] = !r_resp_ready[c];
          hold_d[c] = mon_dat;
        end else begin
          if (hold_v[c]) chk("resp_valid_held", 64'(r_resp_valid[c]), 64'd1);
          hold_v[c] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [63:0] idx, input logic [63:0] dat, input logic [63:0] msk);
    w_valid = 1'b1;
    w_index = idx;
    w_data  = dat;
    w_mask  = msk;
    step();
    w_valid = 1'b0;
  endtask

  task automatic rd(input int c, input logic [63:0] idx);
    r_req_valid[c] = 1'b1;
    r_req_index[c*64 +: 64] = idx;
    step();
    r_req_valid[c] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0) && n < 200) begin
      step();
      n++;
    end
    step();
    chk("drain_q0", 64'(exp0.size()), 64'd0);
    chk("drain_q1", 64'(exp1.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    r_req_valid  = '0;
    r_resp_ready = '0;
    r_req_index  = '0;
    w_valid      = 1'b0;
    w_index      = '0;
    w_data       = '0;
    w_mask       = '0;
    hold_v[0]    = 1'b0;
    hold_v[1]    = 1'b0;

    // Reset values
    repeat (2) @(negedge clock);
    chk("rst_req_ready", 64'(r_req_ready), 64'd0);
    chk("rst_resp_valid", 64'(r_resp_valid), 64'd0);
    chk("rst_resp_data0", r_resp_data[63:0], 64'd0);
    chk("rst_resp_data1", r_resp_data[127:64], 64'd0);
    chk("rst_w_ready", 64'(w_ready), 64'd0);
    chk("rst_oob_err", 64'(oob_err), 64'd0);
    #2 reset_n = 1'b1;
    step();
    @(negedge clock);
    chk("up_w_ready", 64'(w_ready), 64'd1);
    chk("up_req_ready", 64'(r_req_ready), 64'd3);

    // Masked write then read with exact latency
    step();
    wr(64'd5, 64'h1122_3344_5566_7788, '1);
    wr(64'd5, '1, 64'h0000_0000_FFFF_FFFF);
    r_resp_ready = 2'b11;
    r_req_valid[0] = 1'b1;
    r_req_index[63:0] = 64'd5;
    @(negedge clock);
    chk("t1_accept", 64'(r_req_ready[0]), 64'd1);
    step();
    r_req_valid[0] = 1'b0;
    @(negedge clock);
    chk("t1_valid_lat1", 64'(r_resp_valid[0]), 64'd0);
    step();
    @(negedge clock);
    chk("t1_valid_lat2", 64'(r_resp_valid[0]), 64'd1);
    chk("t1_data", r_resp_data[63:0], 64'h1122_3344_FFFF_FFFF);
    drain();

    // Write-first on a same-cycle collision
    w_valid = 1'b1; w_index = 64'd9; w_data = 64'hAB; w_mask = '1;
    r_req_valid[1] = 1'b1; r_req_index[127:64] = 64'd9;
    step();
    w_valid = 1'b0; r_req_valid[1] = 1'b0;
    step();
    @(negedge clock);
    chk("t2_valid", 64'(r_resp_valid[1]), 64'd1);
    chk("t2_data", r_resp_data[127:64], 64'hAB);
    drain();

    // Credit exhaustion on ch0 with ch1 independent
    for (int i = 0; i < 6; i++) wr(64'(100 + i), 64'hC0C0_0000_0000_0000 | 64'(i), '1);
    r_resp_ready[0] = 1'b0;
    acc_n = 0;
    r_req_valid[0] = 1'b1;
    r_req_index[63:0] = 64'd100;
    r_req_valid[1] = 1'b1;
    r_req_index[127:64] = 64'd101;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clock);
      if (r_req_valid[0] && r_req_ready[0]) acc_n++;
      step();
      r_req_index[63:0] = 64'(100 + acc_n);
      r_req_valid[1] = 1'b0;
    end
    @(negedge clock);
    chk("t3_accepted", 64'(acc_n), 64'd4);
    chk("t3_ch0_ready", 64'(r_req_ready[0]), 64'd0);
    chk("t3_ch1_ready", 64'(r_req_ready[1]), 64'd1);
    step();
    r_resp_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 40 && acc_n < 6; cyc++) begin
      @(negedge clock);
      if (r_req_valid[0] && r_req_ready[0]) acc_n++;
      step();
      r_req_index[63:0] = 64'(100 + acc_n);
      if (acc_n >= 6) r_req_valid[0] = 1'b0;
    end
    r_req_valid[0] = 1'b0;
    chk("t3_accepted_all", 64'(acc_n), 64'd6);
    drain();

    // Reset with responses queued
    r_resp_ready[0] = 1'b0;
    rd(0, 64'd100);
    rd(0, 64'd101);
    rd(0, 64'd102);
    step();
    step();
    @(negedge clock);
    chk("t5_queued_valid", 64'(r_resp_valid[0]), 64'd1);
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(r_resp_valid), 64'd0);
    chk("t5_rst_req_ready", 64'(r_req_ready), 64'd0);
    exp0.delete();
    exp1.delete();
    @(negedge clock);
    chk("t5_rst_req_ready_hold", 64'(r_req_ready), 64'd0);
    #2 reset_n = 1'b1;
    step();
    @(negedge clock);
    chk("t5_post_req_ready", 64'(r_req_ready), 64'd3);
    chk("t5_post_valid", 64'(r_resp_valid), 64'd0);
    step();
    r_resp_ready = 2'b11;
    rd(0, 64'd5);
    step();
    @(negedge clock);
    chk("t5_keep_valid", 64'(r_resp_valid[0]), 64'd1);
    chk("t5_keep_data", r_resp_data[63:0], 64'h1122_3344_FFFF_FFFF);
    drain();

    // Random streaming on both channels with response stalls
    for (int i = 0; i < 16; i++) wr(64'(i), {$urandom(), $urandom()}, '1);
    nxt[0] = 0;
    nxt[1] = 0;
    for (int cyc = 0; cyc < 600 && (nxt[0] < 32 || nxt[1] < 32); cyc++) begin
      @(negedge clock);
      acc_now = r_req_valid & r_req_ready;
      step();
      for (int c = 0; c < 2; c++) begin
        if (acc_now[c]) begin
          nxt[c]++;
          r_req_valid[c] = 1'b0;
        end
        if (!r_req_valid[c] && nxt[c] < 32 && $urandom_range(0, 3) != 0) begin
          r_req_valid[c] = 1'b1;
          r_req_index[c*64 +: 64] = 64'(nxt[c] % 16);
        end
      end
      r_resp_ready = 2'($urandom_range(0, 3));
    end
    r_req_valid = '0;
    r_resp_ready = 2'b11;
    chk("t4_issued_ch0", 64'(nxt[0]), 64'd32);
    chk("t4_issued_ch1", 64'(nxt[1]), 64'd32);
    drain();

    // Out-of-range index handling
    wr(64'd3, 64'h3333_3333_3333_3333, '1);
    wr(64'h0000_0000_0010_0003, 64'h5A5A_5A5A_5A5A_5A5A, '1);
    rd(0, 64'd3);
    step();
    @(negedge clock);
    chk("t6_idx3_valid", 64'(r_resp_valid[0]), 64'd1);
    chk("t6_idx3_data", r_resp_data[63:0], EXP_IDX3);
    drain();
    rd(1, 64'h0000_0000_0010_0000);
    drain();
    @(negedge clock);
    chk("t6_oob_err", 64'(oob_err), EXP_OOB);
    chk("t6_oob_model", 64'(oob_err), 64'(ref_oob));
    repeat (3) step();
    @(negedge clock);
    chk("t6_oob_sticky", 64'(oob_err), EXP_OOB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
